plic: RTL and testbench
=======================

Name: plic

Overview:
- Platform-level interrupt controller that shares the core's single machine external interrupt line among NSRC device interrupt sources.
- Per-source gateways latch requests. A priority arbiter selects the best enabled, pending source above a threshold, and drives `meip` into the CSR unit.
- Software discovers and retires the interrupt through a memory-mapped claim/complete register on the core's peripheral bus (`mem_valid`/`mem_ready` style).

Parameters:
- NSRC, 8, number of interrupt sources, legal range 1..31; source ID 0 is reserved and means "none".
- PRIO_W, 3, priority width in bits; priority 0 means never interrupt.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- irq_src  input  NSRC  source request levels; bit i-1 is source ID i
- mem_valid  input  1  bus request strobe, one cycle per access
- mem_addr  input  8  byte offset within the block; bits [1:0] are ignored
- mem_wdata  input  32  write data
- mem_wstrb  input  4  byte write strobes; nonzero means write, zero means read
- mem_rdata  output  32  read data, valid while mem_ready=1
- mem_ready  output  1  access-done pulse
- meip  output  1  machine external interrupt pending, to the CSR unit

Behaviour:
- Reset state: mem_ready=0, mem_rdata=0, meip=0. All priority, enable, threshold, pending and in-flight state is 0. Asserting reset mid-transaction aborts it; no mem_ready is issued.
- Register map (offsets):
  - 0x04*i priority[i] for i=1..NSRC, RW, low PRIO_W bits used.
  - 0x00 reads 0.
  - 0x80 pending, RO, bit i = source i.
  - 0x84 enable, RW, bit i = source i; bit 0 is hardwired 0.
  - 0x88 threshold, RW, PRIO_W bits.
  - 0x8C claim/complete.
  - Unmapped offsets read 0; writes to them are ignored.
- Bus handshake:
  - mem_valid sampled at edge t → mem_ready=1 for exactly the cycle after edge t+1, with mem_rdata valid in that cycle.
  - Writes take effect at edge t.
  - mem_rdata returns to 0 when mem_ready=0.
  - mem_valid asserted during the mem_ready cycle is accepted as a new access.
  - Partial write strobes update only the selected bytes.
- Gateway (level mode), per source:
  - pending[i] sets at an edge where irq_src[i]=1, pending[i]=0 and inflight[i]=0.
  - pending[i] is not cleared by irq_src deasserting.
- Arbiter, combinational on registered state:
  - Candidate: pending & enable & priority>threshold.
  - Winner: highest priority; on a tie, the lowest ID wins.
  - best_id = 0 if there is no candidate.
  - meip is registered: meip <= (best_id!=0), one edge after the state change.
- Claim (read of 0x8C at edge t):
  - mem_rdata = best_id as seen at edge t.
  - If best_id!=0: at edge t, pending[best_id] clears and inflight[best_id] sets.
  - A read with no candidate returns 0 and changes nothing.
- Complete (write of 0x8C with data ID):
  - If 1<=ID<=NSRC and inflight[ID]=1, inflight[ID] clears at edge t. Otherwise the write is ignored.
  - Enable state does not gate completion.
- Simultaneous events:
  - Complete and irq_src[ID]=1 in the same cycle: pending re-sets at the next edge, not the same edge.
  - A claim and a new request from a different source in the same cycle: both take effect.
  - Changing priority, enable or threshold while meip=1: meip updates on the following edge.
- Latency:
  - irq_src high before edge 0 → pending visible after edge 0 → meip=1 after edge 1.
  - Claim at edge t → meip reflects the new arbitration after edge t+1.

Optional Feature:
- Macro PLIC_EDGE_EN.
- Defined: gateways are rising-edge triggered.
  - A registered copy of irq_src is kept; pending[i] sets on a 0→1 transition while inflight[i]=0.
  - A held-high level never re-triggers.
  - An edge that arrives while inflight[i]=1 is dropped.
- Undefined: the level gateway above; no previous-value register is instantiated.

Test Plan:
- Reset then read 0x80, 0x84, 0x88, 0x8C → all return 0; meip=0; each access gives mem_ready one cycle after mem_valid.
- priority[3]=2, enable=0x08, threshold=0; raise irq_src[2] → meip=1 two edges later; read 0x8C → 3; meip=0; pending bit3=0.
- priority[2]=5, priority[5]=5, priority[6]=7, enable=0x64, raise sources 2, 5, 6 → claims return 6, then 2, then 5, then 0, with completes written in between.
- Threshold=5, priority[4]=5, source 4 high and enabled → meip stays 0. Set threshold=4 → meip=1 the edge after the write takes effect.
- Hold source 1 high, claim → 1. Write 0x8C=7 (not in flight) → no effect, no re-pend. Write 0x8C=1 → pending bit1 re-sets, meip=1 again in level mode. With PLIC_EDGE_EN, no re-pend until a new 0→1 edge.
- Assert rst between mem_valid and mem_ready of a claim → no mem_ready, all state 0, meip=0 immediately (asynchronous).

Source files
------------

// File: rtl/plic.sv
// Platform-level interrupt controller: NSRC gateways, priority arbiter and a claim/complete bus slave driving meip.
// Optional PLIC_EDGE_EN selects rising-edge gateways instead of the default level gateways.
module plic #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            mem_valid,
  input  logic [7:0]      mem_addr,
  input  logic [31:0]     mem_wdata,
  input  logic [3:0]      mem_wstrb,
  output logic [31:0]     mem_rdata,
  output logic            mem_ready,
  output logic            meip
);

  localparam int IDW = 5;
  typedef logic [IDW-1:0] id_t;

  localparam logic [5:0] W_PENDING = 6'd32;
  localparam logic [5:0] W_ENABLE  = 6'd33;
  localparam logic [5:0] W_THRESH  = 6'd34;
  localparam logic [5:0] W_CLAIM   = 6'd35;

  logic [NSRC:1][PRIO_W-1:0] prio_q, prio_d;
  logic [NSRC:0]             enable_q, enable_d;
  logic [NSRC:0]             pending_q, pending_d;
  logic [NSRC:0]             inflight_q, inflight_d;
  logic [PRIO_W-1:0]         thresh_q, thresh_d;
  logic                      acc_q;
  logic [31:0]               rd_stage_q, rd_stage_d;
  logic                      meip_q;

  logic [5:0]      word;
  logic            is_wr, is_rd;
  logic [31:0]     wmask, rd_data, merged, cid;
  logic [NSRC-1:0] trig;
  id_t             best_id;
  logic [PRIO_W-1:0] best_prio;

  assign word  = mem_addr[7:2];
  assign is_wr = mem_valid && (mem_wstrb != 4'b0000);
  assign is_rd = mem_valid && (mem_wstrb == 4'b0000);
  assign wmask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign cid   = mem_wdata & wmask;

`ifdef PLIC_EDGE_EN
  logic [NSRC-1:0] irq_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_prev_q <= '0;
    else     irq_prev_q <= irq_src;
  end

  assign trig = irq_src & ~irq_prev_q;
`else
  assign trig = irq_src;
`endif

  // Strict '>' while scanning upward keeps the lowest ID on a priority tie.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (pending_q[i] && enable_q[i] && (prio_q[i] > thresh_q) && (prio_q[i] > best_prio)) begin
        best_id   = id_t'(i);
        best_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (word == 6'(i)) rd_data = 32'(prio_q[i]);
    end
    case (word)
      W_PENDING: rd_data = 32'(pending_q);
      W_ENABLE:  rd_data = 32'(enable_q);
      W_THRESH:  rd_data = 32'(thresh_q);
      W_CLAIM:   rd_data = 32'(best_id);
      default:   ;
    endcase
  end

  // The addressed register's current value supplies the bytes not selected by the strobes.
  assign merged = (rd_data & ~wmask) | (mem_wdata & wmask);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    prio_d     = prio_q;
    enable_d   = enable_q;
    pending_d  = pending_q;
    inflight_d = inflight_q;
    thresh_d   = thresh_q;
    rd_stage_d = is_rd ? rd_data : 32'd0;

    // Registered inflight gates the gateway, so a completion re-pends one edge later.
    for (int i = 1; i <= NSRC; i++) begin
      if (trig[i-1] && !inflight_q[i]) pending_d[i] = 1'b1;
    end

    if (is_wr) begin
      for (int i = 1; i <= NSRC; i++) begin
        if (word == 6'(i)) prio_d[i] = merged[PRIO_W-1:0];
        if ((word == W_CLAIM) && (cid == 32'(i)) && inflight_q[i]) inflight_d[i] = 1'b0;
      end
      if (word == W_ENABLE) enable_d = merged[NSRC:0];
      if (word == W_THRESH) thresh_d = merged[PRIO_W-1:0];
    end

    if (is_rd && (word == W_CLAIM) && (best_id != '0)) begin
      for (int i = 1; i <= NSRC; i++) begin
        if (best_id == id_t'(i)) begin
          pending_d[i]  = 1'b0;
          inflight_d[i] = 1'b1;
        end
      end
    end

    enable_d[0]   = 1'b0;
    pending_d[0]  = 1'b0;
    inflight_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the small priority array is reset like any other register; software expects it to read 0.
      prio_q     <= '0;
      enable_q   <= '0;
      pending_q  <= '0;
      inflight_q <= '0;
      thresh_q   <= '0;
      acc_q      <= 1'b0;
      rd_stage_q <= '0;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      meip_q     <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      thresh_q   <= thresh_d;
      acc_q      <= mem_valid;
      rd_stage_q <= rd_stage_d;
      mem_ready  <= acc_q;
      mem_rdata  <= acc_q ? rd_stage_q : 32'd0;
      meip_q     <= (best_id != '0);
    end
  end

  assign meip = meip_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, mem_addr[1:0], merged};

endmodule

// File: tb/tb_plic.sv
// Self-checking bench for plic: register vector table, scoreboarded bus reads and hand-written interrupt sequences.
module tb_plic;

  localparam int NSRC   = 8;
  localparam int PRIO_W = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] irq_src = '0;
  logic            mem_valid = 1'b0;
  logic [7:0]      mem_addr = '0;
  logic [31:0]     mem_wdata = '0;
  logic [3:0]      mem_wstrb = '0;
  logic [31:0]     mem_rdata;
  logic            mem_ready;
  logic            meip;

  plic #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .meip      (meip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
    bit          chk;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    bit          chk;
    string       name;
  } sb_t;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: each mem_ready cycle retires the oldest outstanding access.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (e.chk) check(e.name, mem_rdata, e.exp);
        end
      end else begin
        check("rdata_idle", mem_rdata, 32'd0);
      end
    end
  end

  task automatic bus(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] exp, input bit chk, input string nm);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    sb.push_back('{exp, chk, nm});
    @(negedge clk);
    check({nm, "_ready_early"}, 32'(mem_ready), 32'd0);
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    @(negedge clk);
    check({nm, "_ready"}, 32'(mem_ready), 32'd1);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(a, d, 4'hF, 32'd0, 1'b0, "wr");
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    bus(a, 32'd0, 4'h0, exp, 1'b1, nm);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  vec_t vecs[24];

  initial begin
    vecs[0]  = '{8'h80, 32'h0,        4'h0, 32'h0,   1'b1};
    vecs[1]  = '{8'h84, 32'h0,        4'h0, 32'h0,   1'b1};
    vecs[2]  = '{8'h88, 32'h0,        4'h0, 32'h0,   1'b1};
    vecs[3]  = '{8'h8C, 32'h0,        4'h0, 32'h0,   1'b1};
    vecs[4]  = '{8'h00, 32'h0,        4'h0, 32'h0,   1'b1};
    vecs[5]  = '{8'h04, 32'hFFFFFFFF, 4'hF, 32'h0,   1'b0};
    vecs[6]  = '{8'h04, 32'h0,        4'h0, 32'h7,   1'b1};
    vecs[7]  = '{8'h84, 32'hFFFFFFFF, 4'hF, 32'h0,   1'b0};
    vecs[8]  = '{8'h84, 32'h0,        4'h0, 32'h1FE, 1'b1};
    vecs[9]  = '{8'h84, 32'h0,        4'h2, 32'h0,   1'b0};
    vecs[10] = '{8'h84, 32'h0,        4'h0, 32'hFE,  1'b1};
    vecs[11] = '{8'h88, 32'h6,        4'hF, 32'h0,   1'b0};
    vecs[12] = '{8'h88, 32'h0,        4'h0, 32'h6,   1'b1};
    vecs[13] = '{8'h08, 32'h305,      4'h2, 32'h0,   1'b0};
    vecs[14] = '{8'h08, 32'h0,        4'h0, 32'h0,   1'b1};
    vecs[15] = '{8'h08, 32'h305,      4'h1, 32'h0,   1'b0};
    vecs[16] = '{8'h08, 32'h0,        4'h0, 32'h5,   1'b1};
    vecs[17] = '{8'h90, 32'hFFFFFFFF, 4'hF, 32'h0,   1'b0};
    vecs[18] = '{8'h90, 32'h0,        4'h0, 32'h0,   1'b1};
    vecs[19] = '{8'h24, 32'hFFFFFFFF, 4'hF, 32'h0,   1'b0};
    vecs[20] = '{8'h24, 32'h0,        4'h0, 32'h0,   1'b1};
    vecs[21] = '{8'hFC, 32'h0,        4'h0, 32'h0,   1'b1};
    vecs[22] = '{8'h07, 32'h2,        4'hF, 32'h0,   1'b0};
    vecs[23] = '{8'h04, 32'h0,        4'h0, 32'h2,   1'b1};

    // Reset state
    wait_cyc(2);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_meip", 32'(meip), 32'd0);
    rst = 1'b0;

    // Register map vectors
    for (int i = 0; i < 24; i++) begin
      bus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp, vecs[i].chk,
          $sformatf("vec%0d", i));
    end

    // Back-to-back reads: the second access is accepted while the first completes
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 8'h84; mem_wstrb = 4'h0;
    sb.push_back('{32'hFE, 1'b1, "b2b_enable"});
    @(negedge clk);
    mem_addr = 8'h88;
    sb.push_back('{32'h6, 1'b1, "b2b_thresh"});
    @(negedge clk);
    mem_valid = 1'b0;
    check("b2b_first_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    check("b2b_second_ready", 32'(mem_ready), 32'd1);

    wr(8'h84, 32'h0);
    wr(8'h88, 32'h0);
    wr(8'h04, 32'h0);
    wr(8'h08, 32'h0);

    // Single source: latency and claim
    wr(8'h0C, 32'h2);
    wr(8'h84, 32'h08);
    irq_src = 8'h04;
    wait_cyc(1);
    check("lat_meip_edge0", 32'(meip), 32'd0);
    wait_cyc(1);
    check("lat_meip_edge1", 32'(meip), 32'd1);
    rd(8'h8C, 32'd3, "claim_src3");
    check("claim3_meip", 32'(meip), 32'd0);
    rd(8'h80, 32'h0, "pend_after_claim3");
    irq_src = '0;
    wr(8'h8C, 32'd3);

    // Priority ordering with a tie between sources 2 and 5
    wr(8'h08, 32'h5);
    wr(8'h14, 32'h5);
    wr(8'h18, 32'h7);
    wr(8'h84, 32'h64);
    irq_src = 8'h32;
    wait_cyc(1);
    irq_src = '0;
    rd(8'h8C, 32'd6, "claim_prio7");
    wr(8'h8C, 32'd6);
    rd(8'h8C, 32'd2, "claim_tie_low_id");
    wr(8'h8C, 32'd2);
    rd(8'h8C, 32'd5, "claim_tie_high_id");
    wr(8'h8C, 32'd5);
    rd(8'h8C, 32'd0, "claim_none");

    // Threshold gating
    wr(8'h88, 32'h5);
    wr(8'h10, 32'h5);
    wr(8'h84, 32'h10);
    irq_src = 8'h08;
    wait_cyc(3);
    check("thr_equal_meip", 32'(meip), 32'd0);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 8'h88; mem_wdata = 32'h4; mem_wstrb = 4'hF;
    sb.push_back('{32'h0, 1'b0, "wr_thr"});
    @(negedge clk);
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    check("thr_meip_same_edge", 32'(meip), 32'd0);
    @(negedge clk);
    check("thr_meip_next_edge", 32'(meip), 32'd1);
    rd(8'h8C, 32'd4, "claim_src4");
    irq_src = '0;
    wr(8'h8C, 32'd4);

    // Held level, bogus complete, real complete
    wr(8'h88, 32'h0);
    wr(8'h04, 32'h3);
    wr(8'h84, 32'h02);
    irq_src = 8'h01;
    wait_cyc(2);
    check("src1_meip", 32'(meip), 32'd1);
    rd(8'h8C, 32'd1, "claim_src1");
    wr(8'h8C, 32'd7);
    rd(8'h80, 32'h0, "pend_after_bogus_complete");
    check("bogus_complete_meip", 32'(meip), 32'd0);
    wr(8'h8C, 32'd1);
`ifdef PLIC_EDGE_EN
    rd(8'h80, 32'h0, "pend_held_no_retrigger");
    wait_cyc(1);
    check("held_meip", 32'(meip), 32'd0);
    irq_src = '0;
    wait_cyc(1);
    irq_src = 8'h01;
    wait_cyc(2);
    check("new_edge_meip", 32'(meip), 32'd1);
    rd(8'h80, 32'h2, "pend_new_edge");
`else
    rd(8'h80, 32'h2, "pend_level_repend");
    wait_cyc(1);
    check("level_repend_meip", 32'(meip), 32'd1);
`endif
    irq_src = '0;
    rd(8'h8C, 32'd1, "claim_src1_again");
    wr(8'h8C, 32'd1);
    wait_cyc(1);
    check("src1_done_meip", 32'(meip), 32'd0);

    // Reset in the middle of a claim
    wr(8'h1C, 32'h1);
    wr(8'h84, 32'h80);
    irq_src = 8'h40;
    wait_cyc(2);
    check("pre_abort_meip", 32'(meip), 32'd1);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 8'h8C; mem_wstrb = 4'h0;
    @(negedge clk);
    mem_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_meip_async", 32'(meip), 32'd0);
    check("abort_ready_async", 32'(mem_ready), 32'd0);
    irq_src = '0;
    wait_cyc(1);
    check("abort_no_ready", 32'(mem_ready), 32'd0);
    wait_cyc(1);
    rst = 1'b0;
    rd(8'h1C, 32'h0, "abort_prio7");
    rd(8'h84, 32'h0, "abort_enable");
    rd(8'h80, 32'h0, "abort_pending");
    rd(8'h8C, 32'h0, "abort_claim");
    check("abort_meip_after", 32'(meip), 32'd0);

    wait_cyc(2);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
